// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DIV_MIN   smallest legal full-period divisor
//   half_hi   length of the high phase for a period of N cycles (ceil(N/2))
//   ch_idx_w  width of a channel index for n channels (never below 1)
package clkdiv_pkg;

    localparam int DIV_MIN = 2;

    // Computed at 32 bits so that N+1 cannot wrap for any DIV_SIZE below 32.
    function automatic logic [31:0] half_hi(input logic [31:0] n);
        return (n + 32'd1) >> 1;
    endfunction

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One programmable divider channel.
//   clock_in   system clock (rising edge)
//   reset_n    asynchronous active-low reset
//   en         run enable; while low the counter is held at phase 0
//   resync     restart at phase 0 and apply any pending divisor
//   wr         validated divisor write for this channel
//   wr_div     divisor carried by the write (already checked >= 2)
//   clock_out  registered divided clock, high for ceil(N/2) of every N cycles
//   tick       registered one-cycle strobe in the first cycle of each period
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_SIZE    = 16,
    parameter int DEFAULT_DIV = 48000
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic                en,
    input  logic                resync,
    input  logic                wr,
    input  logic [DIV_SIZE-1:0] wr_div,
    output logic                clock_out,
    output logic                tick
);

    logic [DIV_SIZE-1:0] r_cnt;
    logic [DIV_SIZE-1:0] r_div_act;
    logic [DIV_SIZE-1:0] r_div_pend;
    logic                r_pend;
    logic                r_clk;
    logic                r_tick;

    logic [DIV_SIZE-1:0] w_half;
    logic                w_wrap;
    logic                w_restart;

    assign w_half    = DIV_SIZE'(half_hi(32'(r_div_act)));
    // div_act is never below 2, so div_act-1 cannot underflow.
    assign w_wrap    = en & (r_cnt == r_div_act - 1'b1);
    // Any of these puts the counter back to phase 0 on this edge; they are
    // also the only points where a new divisor may take effect.
    assign w_restart = resync | ~en | w_wrap;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_div_act  <= DIV_SIZE'(DEFAULT_DIV);
            r_div_pend <= '0;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            // Outputs reflect the phase held before this edge.
            r_clk  <= en & (r_cnt < w_half);
            r_tick <= en & (r_cnt == '0);

            r_cnt <= w_restart ? '0 : r_cnt + 1'b1;

            if (wr && w_restart) begin
                // Boundary write: takes over directly and drops any older pending value.
                r_div_act <= wr_div;
                r_pend    <= 1'b0;
            end else if (wr) begin
                // Mid-period write: parked until the next boundary, last one wins.
                r_div_pend <= wr_div;
                r_pend     <= 1'b1;
            end else if ((resync || w_wrap) && r_pend) begin
                r_div_act <= r_div_pend;
                r_pend    <= 1'b0;
            end
        end
    end

    assign clock_out = r_clk;
    assign tick      = r_tick;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers on one system clock.
//   clock_in   system clock (rising edge)
//   reset_n    asynchronous active-low reset
//   ch_en      per-channel run enable
//   resync     one-cycle pulse restarting every channel at phase 0
//   cfg_valid  divisor write strobe
//   cfg_ch     target channel of the write
//   cfg_div    new full-period divisor
//   cfg_err    one-cycle pulse when a write is rejected (divisor < 2 or bad channel)
//   clock_out  divided clock per channel
//   tick       period-start strobe per channel
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_SIZE    = 16,
    parameter int DEFAULT_DIV = 48000,
    localparam int CH_W       = ch_idx_w(NUM_CH)
) (
    input  logic                clock_in,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                resync,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_SIZE-1:0] cfg_div,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clock_out,
    output logic [NUM_CH-1:0]   tick
);

    logic              w_ok;
    logic [NUM_CH-1:0] w_wr;
    logic              r_cfg_err;

    // cfg_ch can encode more values than there are channels when NUM_CH is
    // not a power of two; those writes are rejected rather than aliased.
    assign w_ok = cfg_valid
                & (cfg_div >= DIV_SIZE'(DIV_MIN))
                & (32'(cfg_ch) < 32'(NUM_CH));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_valid & ~w_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_wr[i] = w_ok & (cfg_ch == CH_W'(i));

        clock_divider_channel #(
            .DIV_SIZE    (DIV_SIZE),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_in  (clock_in),
            .reset_n   (reset_n),
            .en        (ch_en[i]),
            .resync    (resync),
            .wr        (w_wr[i]),
            .wr_div    (cfg_div),
            .clock_out (clock_out[i]),
            .tick      (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
module tb_multi_clock_divider;

    localparam int NCH = 3;
    localparam int DS  = 16;
    localparam int DEF = 48000;
    localparam int CW  = 2;

    logic           clock_in = 1'b0;
    logic           reset_n  = 1'b0;
    logic [NCH-1:0] ch_en;
    logic           resync;
    logic           cfg_valid;
    logic [CW-1:0]  cfg_ch;
    logic [DS-1:0]  cfg_div;
    logic           cfg_err;
    logic [NCH-1:0] clock_out;
    logic [NCH-1:0] tick;

    always #5 clock_in = ~clock_in;

    multi_clock_divider #(
        .NUM_CH      (NCH),
        .DIV_SIZE    (DS),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .ch_en     (ch_en),
        .resync    (resync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clock_out (clock_out),
        .tick      (tick)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Reference model: each channel remembers the edge index at which its
    // current period began; phase is simply (edge - start).
    int cyc = 0;
    int m_start[NCH];
    int m_n[NCH];
    int m_pend[NCH];   // 0 = nothing pending (a legal divisor is >= 2)
    bit e_clk[NCH];
    bit e_tick[NCH];
    bit e_err;

    task automatic model_step();
        bit ok, w, boundary, wrap;
        int ph;
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_start[c] = cyc; m_n[c] = DEF; m_pend[c] = 0;
                e_clk[c] = 0; e_tick[c] = 0;
            end
            e_err = 0;
        end else begin
            ok = cfg_valid && (cfg_div >= 2) && (int'(cfg_ch) < NCH);
            e_err = cfg_valid && !ok;
            for (int c = 0; c < NCH; c++) begin
                ph = cyc - m_start[c];
                w  = ok && (int'(cfg_ch) == c);
                e_clk[c]  = ch_en[c] && (ph < (m_n[c] + 1) / 2);
                e_tick[c] = ch_en[c] && (ph == 0);
                wrap = ch_en[c] && (ph == m_n[c] - 1);
                boundary = resync || !ch_en[c] || wrap;
                if (boundary) m_start[c] = cyc + 1;
                if (w && boundary) begin
                    m_n[c] = int'(cfg_div); m_pend[c] = 0;
                end else if (w) begin
                    m_pend[c] = int'(cfg_div);
                end else if ((resync || wrap) && m_pend[c] != 0) begin
                    m_n[c] = m_pend[c]; m_pend[c] = 0;
                end
            end
            cyc++;
        end
    endtask

    initial forever begin
        @(posedge clock_in or negedge reset_n);
        model_step();
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clock_in);
        if (chk_on && reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("clk%0d@%0d", c, cyc), int'(clock_out[c]), int'(e_clk[c]));
                chk($sformatf("tick%0d@%0d", c, cyc), int'(tick[c]), int'(e_tick[c]));
            end
            chk($sformatf("err@%0d", cyc), int'(cfg_err), int'(e_err));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic wr(input int ch, input int div);
        cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_div = DS'(div);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int hi, tk, k;
        logic [9:0]  v10, t10;
        logic [15:0] v16;
        logic [11:0] v12, t12;

        ch_en = '0; resync = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0;
        step(3);
        chk("rst_clk", int'(clock_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_err", int'(cfg_err), 0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        step(2);

        // Default divisor on channel 0: 24000 high, 24000 low, one tick per period.
        ch_en[0] = 1'b1;
        step();
        chk("t1_first_tick", int'(tick[0]), 1);
        chk("t1_first_hi", int'(clock_out[0]), 1);
        hi = 1; tk = 1;
        for (int i = 1; i < 48000; i++) begin
            step();
            hi += int'(clock_out[0]);
            tk += int'(tick[0]);
        end
        chk("t1_high_cycles", hi, 24000);
        chk("t1_ticks", tk, 1);
        step();
        chk("t1_second_tick", int'(tick[0]), 1);

        // Odd divisor written while disabled: HHHLL.
        wr(1, 5);
        ch_en[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            v10[9-i] = clock_out[1];
            t10[9-i] = tick[1];
        end
        chk("t2_clk_pattern", int'(v10), 'b1110011100);
        chk("t2_tick_pattern", int'(t10), 'b1000010000);

        // Mid-period rewrite: current 8-cycle period finishes, then 4-cycle periods.
        wr(2, 8);
        ch_en[2] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin
                cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4;
            end else begin
                cfg_valid = 1'b0;
            end
            step();
            v16[15-i] = clock_out[2];
        end
        cfg_valid = 1'b0;
        chk("t3_clk_pattern", int'(v16), 'b1111000011001100);

        // Rejected writes.
        wr(0, 1);
        chk("t4_err_div1", int'(cfg_err), 1);
        step();
        chk("t4_err_clear1", int'(cfg_err), 0);
        wr(3, 7);
        chk("t4_err_badch", int'(cfg_err), 1);
        step();
        chk("t4_err_clear2", int'(cfg_err), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                k = int'($urandom_range(0, NCH - 1));
                ch_en[k] = ~ch_en[k];
            end
            resync    = ($urandom_range(0, 99) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_ch    = CW'($urandom_range(0, 3));
            cfg_div   = DS'($urandom_range(0, 12));
            step();
        end
        resync = 0; cfg_valid = 0;

        // Resync aligns N=6 and N=10 channels; they coincide every 30 cycles.
        ch_en = '0;
        step();
        wr(0, 6);
        wr(1, 10);
        ch_en[0] = 1'b1;
        step(3);
        ch_en[1] = 1'b1;
        step(7);
        resync = 1'b1;
        step();
        resync = 1'b0;
        step();
        chk("t5_tick0", int'(tick[0]), 1);
        chk("t5_tick1", int'(tick[1]), 1);
        chk("t5_hi_both", int'(clock_out[1:0]), 3);
        step(30);
        chk("t5_tick0_30", int'(tick[0]), 1);
        chk("t5_tick1_30", int'(tick[1]), 1);

        // Reset mid-high-phase with a pending write.
        step();
        chk("t6_mid_high", int'(clock_out[0]), 1);
        wr(0, 9);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_clk", int'(clock_out), 0);
        chk("t6_async_tick", int'(tick), 0);
        ch_en = '0;
        step(2);
        reset_n  = 1'b1;
        ch_en[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            v12[11-i] = clock_out[0];
            t12[11-i] = tick[0];
        end
        chk("t6_default_hi", int'(v12), 'hFFF);
        chk("t6_default_tick", int'(t12), 'h800);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
